// File: rtl/viterbi_ber_checker.sv
// Post-decode BER scoreboard for the encode -> channel -> Viterbi path.
// It keeps a history of the bits entering the encoder and searches for the
// offset at which the decoded bits line up with that history. Once a run of
// matches is found at one offset it locks there, then counts the decoded bits
// and the bit errors until the recent error density forces it to search again.
//
// Handshake: tx_valid_i and rx_valid_i are plain qualifiers with no
// backpressure. A bit is consumed on every rising edge where its valid is
// high, and it is ignored when valid is low.
module viterbi_ber_checker #(
  parameter int MAX_LAT    = 64,
  parameter int LOCK_RUN   = 16,
  parameter int UNLOCK_ERR = 8,
  parameter int CW         = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_valid_i,
  input  logic                       tx_bit_i,
  input  logic                       rx_valid_i,
  input  logic                       rx_bit_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] latency_o,
  output logic [CW-1:0]              bit_ct_o,
  output logic [CW-1:0]              err_ct_o,
  output logic                       err_flag_o
);

  localparam int LW = $clog2(MAX_LAT);
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam logic [LW:0]   FILL_MAX = (LW + 1)'(MAX_LAT);
  localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_RUN - 1);
  localparam logic [5:0]    ERR_LIM  = 6'(UNLOCK_ERR);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [MAX_LAT-1:0] hist;
  logic [LW:0]        fill_ct;
  logic [0:0]         state;
  logic [LW-1:0]      d;
  logic [RW-1:0]      run_ct;
  logic [31:0]        window;
  logic [CW-1:0]      bit_ct;
  logic [CW-1:0]      err_ct;
  logic               err_flag;

  logic               mis;
  logic               in_range;
  logic [31:0]        win_next;
  logic [5:0]         win_pop;

  // Compare against the registered history; a same-cycle tx shift is not yet visible.
  always_comb begin
    mis      = rx_bit_i ^ hist[d];
    in_range = fill_ct > {1'b0, d};
    win_next = {window[30:0], mis};
    win_pop  = 6'($countones(win_next));
  end

  // Transmit history: newest bit at index 0, fill count saturates at the depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist    <= '0;
      fill_ct <= '0;
    end else if (tx_valid_i) begin
      hist <= {hist[MAX_LAT-2:0], tx_bit_i};
      if (fill_ct != FILL_MAX) fill_ct <= fill_ct + 1'b1;
    end
  end

  // Offset search / lock tracking, counters and the error window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SEARCH;
      d        <= '0;
      run_ct   <= '0;
      window   <= '0;
      bit_ct   <= '0;
      err_ct   <= '0;
      err_flag <= 1'b0;
    end else begin
      err_flag <= 1'b0;
      if (clear_i) begin
        bit_ct <= '0;
        err_ct <= '0;
        window <= '0;
      end
      case (state)
        SEARCH: begin
          if (rx_valid_i && in_range) begin
            if (!mis) begin
              if (run_ct == RUN_LAST) begin
                state  <= LOCKED;
                run_ct <= '0;
                window <= '0;
              end else begin
                run_ct <= run_ct + 1'b1;
              end
            end else begin
              // Offset depth is a power of two, so the increment wraps to 0.
              run_ct <= '0;
              d      <= d + 1'b1;
            end
          end
        end
        LOCKED: begin
          // A same-cycle clear wins: the bit is neither counted nor windowed.
          if (rx_valid_i && !clear_i) begin
            if (bit_ct != '1) bit_ct <= bit_ct + 1'b1;
            if (mis) begin
              if (err_ct != '1) err_ct <= err_ct + 1'b1;
              err_flag <= 1'b1;
            end
            window <= win_next;
            if (win_pop >= ERR_LIM) begin
              state  <= SEARCH;
              d      <= '0;
              run_ct <= '0;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign locked_o   = (state == LOCKED);
  assign latency_o  = d;
  assign bit_ct_o   = bit_ct;
  assign err_ct_o   = err_ct;
  assign err_flag_o = err_flag;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: random tx stream with a delayed/corrupted rx
// copy, a queue-based reference model, and a monitor comparing every cycle.
module tb_viterbi_ber_checker;

  localparam int MAX_LAT = 64;
  localparam int DLY     = 5;
  localparam int EW      = 72;

  logic        clk;
  logic        rst;
  logic        tx_valid, tx_bit, rx_valid, rx_bit, clear;
  logic        locked, err_flag, locked4, err_flag4;
  logic [5:0]  latency, latency4;
  logic [31:0] bit_ct, err_ct;
  logic [3:0]  bit_ct4, err_ct4;

  viterbi_ber_checker #(.MAX_LAT(64), .LOCK_RUN(16), .UNLOCK_ERR(8), .CW(32)) u_dut (
    .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_bit_i(tx_bit),
    .rx_valid_i(rx_valid), .rx_bit_i(rx_bit), .clear_i(clear),
    .locked_o(locked), .latency_o(latency), .bit_ct_o(bit_ct),
    .err_ct_o(err_ct), .err_flag_o(err_flag)
  );

  viterbi_ber_checker #(.MAX_LAT(64), .LOCK_RUN(16), .UNLOCK_ERR(8), .CW(4)) u_dut4 (
    .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_bit_i(tx_bit),
    .rx_valid_i(rx_valid), .rx_bit_i(rx_bit), .clear_i(clear),
    .locked_o(locked4), .latency_o(latency4), .bit_ct_o(bit_ct4),
    .err_ct_o(err_ct4), .err_flag_o(err_flag4)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int pulse_ct = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model state, kept at the level of the behavioural rules.
  bit     m_hist[$];
  bit     m_win[$];
  int     m_d, m_run;
  bit     m_locked, m_flag;
  longint m_bit, m_err;
  bit     txlog[$];
  int     rx_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat4(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_hist.delete(); m_win.delete();
    m_d = 0; m_run = 0; m_locked = 0; m_flag = 0; m_bit = 0; m_err = 0;
  endtask

  task automatic model_step(input bit tv, input bit tb, input bit rv, input bit rb, input bit clr);
    bit mis;
    int s;
    m_flag = 0;
    if (rv) begin
      if (!m_locked) begin
        if (m_hist.size() > m_d) begin
          if (rb == m_hist[m_d]) begin
            m_run++;
            if (m_run == 16) begin
              m_locked = 1; m_run = 0; m_win.delete();
            end
          end else begin
            m_run = 0;
            m_d = (m_d + 1) % MAX_LAT;
          end
        end
      end else if (!clr) begin
        mis = (rb != m_hist[m_d]);
        m_bit++;
        if (mis) begin
          m_err++;
          m_flag = 1;
        end
        m_win.push_back(mis);
        if (m_win.size() > 32) void'(m_win.pop_front());
        s = 0;
        foreach (m_win[i]) s += int'(m_win[i]);
        if (s >= 8) begin
          m_locked = 0; m_d = 0; m_run = 0;
        end
      end
    end
    if (clr) begin
      m_bit = 0; m_err = 0; m_win.delete();
    end
    if (tv) begin
      m_hist.push_front(tb);
      if (m_hist.size() > MAX_LAT) void'(m_hist.pop_back());
    end
  endtask

  // Driver: apply inputs just after a falling edge, queue the expected outputs
  // for the following rising edge, then move to the next cycle.
  task automatic step(input bit tv, input bit tb, input bit rv, input bit rb, input bit clr);
    logic [31:0] eb, ee;
    tx_valid = tv; tx_bit = tb; rx_valid = rv; rx_bit = rb; clear = clr;
    model_step(tv, tb, rv, rb, clr);
    eb = m_bit[31:0];
    ee = m_err[31:0];
    exp_q.push_back({m_locked, 6'(m_d), eb, ee, m_flag});
    @(negedge clk);
    #1;
  endtask

  // mode 0: clean delayed copy, 1: flip every 16th rx bit, 2: invert every rx bit
  task automatic run_stream(input int n, input int mode);
    bit tb, rv, rb;
    for (int i = 0; i < n; i++) begin
      tb = 1'($urandom_range(0, 1));
      rv = 0;
      rb = 0;
      if (txlog.size() > DLY) begin
        rv = 1;
        rb = txlog[txlog.size() - 1 - DLY];
        if (mode == 1 && (rx_idx % 16) == 15) rb = ~rb;
        if (mode == 2) rb = ~rb;
        rx_idx++;
      end
      step(1, tb, rv, rb, 0);
      txlog.push_back(tb);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, 64'(locked), 0);
    chk({tag, "_lat"}, 64'(latency), 0);
    chk({tag, "_bit"}, 64'(bit_ct), 0);
    chk({tag, "_err"}, 64'(err_ct), 0);
    chk({tag, "_flag"}, 64'(err_flag), 0);
    chk({tag, "_locked4"}, 64'(locked4), 0);
    chk({tag, "_bit4"}, 64'(bit_ct4), 0);
  endtask

  initial begin
    int p0;
    bit tb, rb;
    rst = 1'b0;
    tx_valid = 0; tx_bit = 0; rx_valid = 0; rx_bit = 0; clear = 0;
    model_reset();
    txlog.delete();
    rx_idx = 0;

    // Monitor: pops one expectation per falling edge and compares both DUTs.
    fork
      forever begin
        logic [EW-1:0] e;
        @(negedge clk);
        if (err_flag) pulse_ct++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("locked", 64'(locked), 64'(e[71]));
          chk("latency", 64'(latency), 64'(e[70:65]));
          chk("bit_ct", 64'(bit_ct), 64'(e[64:33]));
          chk("err_ct", 64'(err_ct), 64'(e[32:1]));
          chk("err_flag", 64'(err_flag), 64'(e[0]));
          chk("locked4", 64'(locked4), 64'(e[71]));
          chk("latency4", 64'(latency4), 64'(e[70:65]));
          chk("bit_ct4", 64'(bit_ct4), 64'(sat4(longint'(e[64:33]))));
          chk("err_ct4", 64'(err_ct4), 64'(sat4(longint'(e[32:1]))));
          chk("err_flag4", 64'(err_flag4), 64'(e[0]));
        end
      end
    join_none

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    #1 rst = 1'b1;
    idle(2);

    // 1: acquisition on a clean stream delayed by 5
    run_stream(200, 0);
    chk("p1_locked", 64'(locked), 1);
    chk("p1_latency", 64'(latency), DLY);
    chk("p1_err", 64'(err_ct), 0);

    // 2: every 16th bit flipped over 320 bits
    step(0, 0, 0, 0, 1);
    p0 = pulse_ct;
    rx_idx = 0;
    run_stream(320, 1);
    idle(1);
    chk("p2_bit", 64'(bit_ct), 320);
    chk("p2_err", 64'(err_ct), 20);
    chk("p2_pulses", 64'(pulse_ct - p0), 20);
    chk("p2_locked", 64'(locked), 1);

    // 3: inverted stream drops lock on the 8th error
    step(0, 0, 0, 0, 1);
    run_stream(7, 2);
    chk("p3_locked_7", 64'(locked), 1);
    run_stream(1, 2);
    chk("p3_locked_8", 64'(locked), 0);
    chk("p3_latency", 64'(latency), 0);
    chk("p3_err", 64'(err_ct), 8);
    run_stream(200, 0);
    chk("p3_relock", 64'(locked), 1);
    chk("p3_relat", 64'(latency), DLY);

    // 4: narrow counter saturates
    step(0, 0, 0, 0, 1);
    run_stream(20, 0);
    chk("p4_bit4", 64'(bit_ct4), 15);
    chk("p4_err4", 64'(err_ct4), 0);
    chk("p4_bit", 64'(bit_ct), 20);

    // 5: clear together with an erroneous rx bit
    run_stream(5, 1);
    tb = 1'($urandom_range(0, 1));
    rb = ~txlog[txlog.size() - 1 - DLY];
    step(1, tb, 1, rb, 1);
    txlog.push_back(tb);
    chk("p5_bit", 64'(bit_ct), 0);
    chk("p5_err", 64'(err_ct), 0);
    chk("p5_flag", 64'(err_flag), 0);
    chk("p5_locked", 64'(locked), 1);
    run_stream(10, 0);

    // 6: asynchronous reset between edges, then reacquire
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check_zero("p6_async");
    model_reset();
    txlog.delete();
    rx_idx = 0;
    tx_valid = 0; rx_valid = 0; clear = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    run_stream(200, 0);
    chk("p6_locked", 64'(locked), 1);
    chk("p6_latency", 64'(latency), DLY);
    chk("p6_err", 64'(err_ct), 0);

    idle(3);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
